// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/long/repeat
// events, plus a registered "held" flag and a wrapping press counter.
module button_event_decoder #(
    parameter int unsigned CLK_FREQ_MHZ = 32'd50,
    parameter int unsigned LONG_MS      = 32'd1000,
    parameter int unsigned REPEAT_MS    = 32'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [31:0] LONG_CYC = LONG_MS * CLK_FREQ_MHZ * 32'd1000;
    localparam logic [31:0] REP_CYC  = REPEAT_MS * CLK_FREQ_MHZ * 32'd1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;

    logic       r_press;
    logic       r_release;
    logic       r_click;
    logic       r_long;
    logic       r_repeat;
    logic       r_held;
    logic [7:0] r_press_count;

    logic       w_press_nxt;
    logic       w_release_nxt;
    logic       w_click_nxt;
    logic       w_long_nxt;
    logic       w_repeat_nxt;
    logic       w_held_nxt;
    logic [7:0] w_press_count_nxt;

    // State, hold counter and every output are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 32'd0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_click       <= 1'b0;
            r_long        <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_press       <= w_press_nxt;
            r_release     <= w_release_nxt;
            r_click       <= w_click_nxt;
            r_long        <= w_long_nxt;
            r_repeat      <= w_repeat_nxt;
            r_held        <= w_held_nxt;
            r_press_count <= w_press_count_nxt;
        end
    end

    // Next state and hold counter; a release always beats a threshold hit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (btn_level) begin
                    w_state_nxt = S_PRESS;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRESS: begin
                if (!btn_level) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LONG_CYC - 32'd1) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                end
            end
            S_HOLD: begin
                if (!btn_level) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == REP_CYC - 32'd1) begin
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    // Pulse and counter values to be registered on the coming edge.
    always_comb begin
        w_press_nxt       = 1'b0;
        w_release_nxt     = 1'b0;
        w_click_nxt       = 1'b0;
        w_long_nxt        = 1'b0;
        w_repeat_nxt      = 1'b0;
        w_press_count_nxt = r_press_count;
        case (r_state)
            S_IDLE: begin
                if (btn_level) begin
                    w_press_nxt       = 1'b1;
                    w_press_count_nxt = r_press_count + 8'd1;
                end else begin
                    w_press_nxt       = 1'b0;
                end
            end
            S_PRESS: begin
                if (!btn_level) begin
                    w_release_nxt = 1'b1;
                    w_click_nxt   = 1'b1;
                end else begin
                    w_long_nxt    = (r_cnt == LONG_CYC - 32'd1);
                end
            end
            S_HOLD: begin
                if (!btn_level) begin
                    w_release_nxt = 1'b1;
                end else begin
                    w_repeat_nxt  = (r_cnt == REP_CYC - 32'd1);
                end
            end
            default: begin
                w_press_nxt = 1'b0;
            end
        endcase
        w_held_nxt = (w_state_nxt != S_IDLE);
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign click_pulse   = r_click;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;
    assign press_count   = r_press_count;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean, debounced button level and turns it into single-cycle user-input events: press, release, click, long-press and auto-repeat.
- Sits between the button debouncer and the game/control FSMs, so downstream logic never edge-detects or times button holds itself.
- Also keeps a wrapping press counter for UI and debug.

Parameters:
CLK_FREQ_MHZ, 50, clock frequency in MHz
LONG_MS, 1000, hold time in ms before long_pulse fires
REPEAT_MS, 200, auto-repeat period in ms after long press
(derived) LONG_CYC = LONG_MS*CLK_FREQ_MHZ*1000; REP_CYC = REPEAT_MS*CLK_FREQ_MHZ*1000; both must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
btn_level  input  1  debounced button level, 1 = pressed, already synchronous to clk
press_pulse  output  1  one-cycle pulse on press
release_pulse  output  1  one-cycle pulse on release
click_pulse  output  1  one-cycle pulse on release before long threshold
long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYC
repeat_pulse  output  1  one-cycle pulse every REP_CYC while held past long
held  output  1  1 while a press is in progress (state != IDLE)
press_count  output  8  number of presses since reset, wraps 255->0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port clk, reset port rst.
- Reset (async assert, any cycle): state=IDLE, cnt=0. All pulse outputs 0, held=0, press_count=0.
  - Reset mid-hold aborts silently: no release or click pulse.
- All outputs are registered. Each pulse is high for exactly one cycle, in the cycle after the clk edge that samples the causing condition.
- Internal hold counter cnt is 32-bit unsigned. The FSM is level-based on btn_level.
- IDLE:
  - On an edge with btn_level=1: state<=PRESS, cnt<=0, press_pulse<=1, press_count<=press_count+1 (mod 256).
  - btn_level already high at reset release is treated as a press on the first edge.
- PRESS:
  - On an edge with btn_level=0: release_pulse<=1, click_pulse<=1, state<=IDLE.
  - Else if cnt==LONG_CYC-1: long_pulse<=1, cnt<=0, state<=HOLD.
  - Else cnt<=cnt+1.
  - Net effect: long_pulse is asserted exactly LONG_CYC cycles after press_pulse.
- HOLD:
  - On an edge with btn_level=0: release_pulse<=1 (no click), state<=IDLE.
  - Else if cnt==REP_CYC-1: repeat_pulse<=1, cnt<=0.
  - Else cnt<=cnt+1.
  - First repeat_pulse comes REP_CYC cycles after long_pulse, then every REP_CYC cycles.
- Simultaneous events: release sampled on the same edge as a threshold hit wins. Only release (and click, if in PRESS) fire; no long or repeat pulse.
- Never more than one of press/long/repeat per cycle. release and click coincide by design.
- held = (state != IDLE), registered with the state.
  - Rises in the same cycle as press_pulse.
  - Falls in the same cycle as release_pulse.
- A 1-cycle low then high on btn_level gives release, then press on the next edge. No filtering here; filtering is the debouncer's job.

Test Plan:
- Reset: assert rst async mid-cycle with btn_level=1 -> all outputs 0 immediately. After release, press_pulse on first edge and press_count=1.
- Short click (bench params CLK_FREQ_MHZ=1, LONG_MS=2, REPEAT_MS=1, so LONG_CYC=2000, REP_CYC=1000): hold btn_level 500 cycles -> press_pulse once, held high 500 cycles, then release_pulse and click_pulse in the same cycle. No long_pulse.
- Long hold 4500 cycles:
  - long_pulse exactly 2000 cycles after press_pulse.
  - repeat_pulse at +3000 and +4000.
  - release_pulse with no click_pulse at release.
- Boundary race: release sampled on the edge where cnt==1999 -> release_pulse and click_pulse, no long_pulse. Same race in HOLD at cnt==999 -> release only, no repeat.
- Counter wrap: 257 short presses -> press_count reads 1. Each press gives exactly one press_pulse.
- Abort: assert rst during HOLD -> no release_pulse. held drops to 0 asynchronously; press_count cleared to 0.
